div_iter: RTL
=============

// Module: div_iter
// PURPOSE
//  Multi-cycle iterative divider for DIV/DIVU. Sits beside the combinational ALU in EXE;
//  EXE issues an operand pair, stalls until the result returns, then writes LO=quotient,
//  HI=remainder. Restoring radix-2, one quotient bit per cycle; valid/ready on both ends.
// PARAMETERS
//  WIDTH   32   operand/result width; iteration count equals WIDTH
// PORTS
//  clk         in   1      clock; single clock domain
//  reset       in   1      synchronous, active-high reset
//  div_valid   in   1      request valid
//  div_ready   out  1      request accepted when div_valid&&div_ready
//  div_signed  in   1      1=DIV (two's complement), 0=DIVU
//  div_src1    in   WIDTH  dividend
//  div_src2    in   WIDTH  divisor
//  div_cancel  in   1      flush (exception/eret in WB); aborts any operation
//  res_valid   out  1      quotient/remainder valid
//  res_ready   in   1      result consumed when res_valid&&res_ready
//  div_quot    out  WIDTH  quotient (to LO)
//  div_rem     out  WIDTH  remainder (to HI)
// BEHAVIOUR
//  - Reset: state=IDLE, res_valid=0, div_quot=0, div_rem=0, counter=0; div_ready=1 (IDLE).
//  - States: IDLE -> CALC on accept; CALC -> DONE after WIDTH iterations; DONE -> IDLE on
//    res_valid&&res_ready. div_ready=(state==IDLE), combinational from state only.
//  - Accept cycle T latches operands, signs, |src1|, |src2| (abs only when div_signed).
//  - CALC: cycles T+1..T+WIDTH; each cycle rem' = {rem[WIDTH-1:0], dvd_msb}; if
//    rem' >= divisor then rem' -= divisor, qbit=1 else qbit=0. rem reg is WIDTH+1 bits.
//  - Sign fix registered on CALC->DONE: quot negated iff signed && (s1^s2); rem negated
//    iff signed && s1. res_valid first high at T+WIDTH+1 (33 cycles for WIDTH=32).
//  - DONE: div_quot/div_rem/res_valid held stable until res_ready; no new request taken
//    in the handshake cycle; div_ready returns the following cycle.
//  - Divisor zero (either mode): div_quot=all-ones, div_rem=div_src1 unmodified; still full
//    WIDTH+1 latency (no early exit).
//  - Signed -2^31 / -1: div_quot=32'h8000_0000, div_rem=0; no trap raised.
//  - div_cancel: any state -> IDLE next cycle, res_valid=0, outputs keep last value; cancel
//    wins over simultaneous div_valid (request not accepted) and over res_ready.
//  - reset mid-operation identical to cancel plus outputs cleared to 0.
//  - Unsigned arithmetic throughout; abs(-2^31) is 2^31 in WIDTH bits, no extension.
// STRUCTURE
//  - State encoding (IDLE/CALC/DONE, 2 bits) local to module; WIDTH-dependent counter
//    width = $clog2(WIDTH)+1.
//  - Shared mycpu.h header gains the EXE<->divider request bus width define only.
//  - No sub-module: datapath (abs, trial subtract, sign fix) is small enough inline.
// TESTING
//  1 DIVU 100/7: accept T -> res_valid at T+33, quot=14, rem=2; held until res_ready.
//  2 DIV -7/2 -> quot=32'hFFFF_FFFD (-3), rem=32'hFFFF_FFFF (-1); 7/-2 -> quot=-3, rem=1.
//  3 DIV 32'h8000_0000/32'hFFFF_FFFF -> quot=32'h8000_0000, rem=0;
//    DIVU same operands -> quot=0, rem=32'h8000_0000.
//  4 Divide by zero: DIV 5/0 -> quot=32'hFFFF_FFFF, rem=5; latency still 33.
//  5 div_cancel at T+10 -> IDLE at T+11, res_valid never asserts; new DIVU 9/3 accepted
//    at T+11 returns quot=3, rem=0 at T+44.
//  6 Backpressure: res_ready low 5 cycles after res_valid -> outputs stable, div_ready=0;
//    handshake cycle -> div_ready=1 next cycle; reset pulse mid-CALC -> outputs 0, IDLE.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared constants and helpers for the iterative DIV/DIVU unit in EXE.
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;

    // Iteration counter must hold values 0..WIDTH-1 with one bit of headroom.
    function automatic int cnt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider: one quotient bit per cycle, sign fix on completion,
// valid/ready on request and result sides, cancel from WB flush.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_cancel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] div_quot,
    output logic [WIDTH-1:0] div_rem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] dvd_r;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] part_rem_r;
    logic [WIDTH-1:0] src1_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             zero_r;
    logic [WIDTH-1:0] quot_out_r;
    logic [WIDTH-1:0] rem_out_r;
    logic             res_valid_r;

    logic             accept_s;
    logic             last_iter_s;
    logic [WIDTH:0]   shift_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quot_next_s;
    logic [WIDTH-1:0] fin_quot_s;
    logic [WIDTH-1:0] fin_rem_s;

    assign div_ready   = (state_r == IDLE);
    assign res_valid   = res_valid_r;
    assign div_quot    = quot_out_r;
    assign div_rem     = rem_out_r;
    assign accept_s    = (state_r == IDLE) && div_valid && !div_cancel;
    assign last_iter_s = (cnt_r == LAST_CNT);

    // Next-state logic; cancel overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_cancel) begin
                    state_nxt_s = IDLE;
                end else if (div_valid) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (div_cancel) begin
                    state_nxt_s = IDLE;
                end else if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (div_cancel || res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // One restoring step plus the final sign/zero-divisor correction.
    always_comb begin
        shift_s     = {part_rem_r, dvd_r[WIDTH-1]};
        ge_s        = (shift_s >= {1'b0, dvs_r});
        quot_next_s = {dvd_r[WIDTH-2:0], ge_s};
        if (ge_s) begin
            rem_next_s = WIDTH'(shift_s - {1'b0, dvs_r});
        end else begin
            rem_next_s = shift_s[WIDTH-1:0];
        end
        // A zero divisor bypasses sign fixing so the dividend comes back untouched.
        if (zero_r) begin
            fin_quot_s = {WIDTH{1'b1}};
            fin_rem_s  = src1_r;
        end else begin
            fin_quot_s = neg_q_r ? ({WIDTH{1'b0}} - quot_next_s) : quot_next_s;
            fin_rem_s  = neg_r_r ? ({WIDTH{1'b0}} - rem_next_s) : rem_next_s;
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= {CW{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            part_rem_r  <= {WIDTH{1'b0}};
            src1_r      <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            zero_r      <= 1'b0;
            quot_out_r  <= {WIDTH{1'b0}};
            rem_out_r   <= {WIDTH{1'b0}};
            res_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r      <= {CW{1'b0}};
                dvd_r      <= magnitude(div_src1, div_signed);
                dvs_r      <= magnitude(div_src2, div_signed);
                part_rem_r <= {WIDTH{1'b0}};
                src1_r     <= div_src1;
                neg_q_r    <= div_signed && (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
                neg_r_r    <= div_signed && div_src1[WIDTH-1];
                zero_r     <= (div_src2 == {WIDTH{1'b0}});
            end
            if ((state_r == CALC) && !div_cancel) begin
                cnt_r      <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                dvd_r      <= quot_next_s;
                part_rem_r <= rem_next_s;
                if (last_iter_s) begin
                    quot_out_r  <= fin_quot_s;
                    rem_out_r   <= fin_rem_s;
                    res_valid_r <= 1'b1;
                end
            end
            if (div_cancel) begin
                res_valid_r <= 1'b0;
            end else if ((state_r == DONE) && res_ready) begin
                res_valid_r <= 1'b0;
            end
        end
    end

endmodule
